imm_ext_stage: RTL and testbench

- Registered, parametrised immediate-generation stage that sits between decode and execute in the pipelined core.
- Takes instruction bits [31:7] plus an immediate-type select and produces an XLEN-wide extended immediate one cycle later.
- Adds a valid/ready handshake with a 2-entry skid buffer, a pass-through tag, a flush input, a CSR zero-extended (Z) immediate type and an illegal-type flag.

---
 rtl/imm_pkg.sv | 23 ++
 rtl/imm_ext_core.sv | 47 ++++
 rtl/imm_ext_stage.sv | 112 +++++++++++
 tb/tb_imm_ext_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg
//   Shared definitions for the immediate-generation blocks.
//   - imm_type_e : immediate type codes carried on imm_src
//   - IMM_SRC_W  : width of the imm_src select
//   - imm_src_illegal() : true for the two unused codes (6, 7)
package imm_pkg;

  localparam int IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4,
    IMM_Z = 3'd5
  } imm_type_e;

  function automatic logic imm_src_illegal(input logic [IMM_SRC_W-1:0] src);
    return (src > 3'd5);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
//   Purely combinational immediate extraction / extension. Shared with the
//   single-cycle datapath, so it carries no state.
// Ports:
//   imm_src  in  3     immediate type (imm_type_e), 6/7 illegal
//   in_data  in  25    instruction bits [31:7]; in_data[k] = instr[k+7]
//   imm      out XLEN  extended immediate (0 for illegal types)
//   err      out 1     imm_src was illegal
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [IMM_SRC_W-1:0] imm_src,
  input  logic [24:0]          in_data,
  output logic [XLEN-1:0]      imm,
  output logic                 err
);

  // 32-bit form of the immediate. For every signed type bit 31 equals
  // in_data[24], so widening to XLEN only needs to replicate bit 31; Z and
  // illegal types have bit 31 clear, which gives zero extension for free.
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_src)
      IMM_I: imm32 = {{20{in_data[24]}}, in_data[24:13]};
      IMM_S: imm32 = {{20{in_data[24]}}, in_data[24:18], in_data[4:0]};
      IMM_B: imm32 = {{19{in_data[24]}}, in_data[24], in_data[0],
                      in_data[23:18], in_data[4:1], 1'b0};
      IMM_J: imm32 = {{11{in_data[24]}}, in_data[24], in_data[12:5],
                      in_data[13], in_data[23:14], 1'b0};
      IMM_U: imm32 = {in_data[24:5], 12'b0};
      IMM_Z: imm32 = {27'b0, in_data[12:8]};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

  assign err = imm_src_illegal(imm_src);

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage
//   Registered immediate-generation stage between decode and execute, with a
//   2-entry skid buffer so upstream never sees a combinational out_ready path.
// Ports:
//   clk, rst_n (async, active-low), flush (sync, drops all entries)
//   in_valid/in_ready, imm_src[2:0], in_data[24:0], in_tag[TAG_W-1:0]
//   out_valid/out_ready, out_imm[XLEN-1:0], out_tag[TAG_W-1:0], out_err
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on the registered entry count; out_valid
// is high whenever the buffer holds an entry and the head outputs hold
// steady until popped. Outputs read 0 while out_valid is low.
module imm_ext_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_SRC_W-1:0] imm_src,
  input  logic [24:0]          in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
);

  logic [XLEN-1:0]  new_imm;
  logic             new_err;

  logic [1:0]       cnt;
  logic [XLEN-1:0]  imm0, imm1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             err0, err1;

  logic             push, pop;

  imm_ext_core #(.XLEN(XLEN)) u_core (
    .imm_src (imm_src),
    .in_data (in_data),
    .imm     (new_imm),
    .err     (new_err)
  );

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Slot 0 is always the head. With one entry, push+pop overwrites the head
  // in place; with two entries only a pop can occur and slot 1 shifts down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      imm0 <= '0;
      imm1 <= '0;
      tag0 <= '0;
      tag1 <= '0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            imm0 <= new_imm;
            tag0 <= in_tag;
            err0 <= new_err;
            cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (push) begin
            if (pop) begin
              imm0 <= new_imm;
              tag0 <= in_tag;
              err0 <= new_err;
            end else begin
              imm1 <= new_imm;
              tag1 <= in_tag;
              err1 <= new_err;
              cnt  <= 2'd2;
            end
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            imm0 <= imm1;
            tag0 <= tag1;
            err0 <= err1;
            cnt  <= 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

  assign out_imm = out_valid ? imm0 : '0;
  assign out_tag = out_valid ? tag0 : '0;
  assign out_err = out_valid && err0;

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage
//   Drives one XLEN=32 and one XLEN=64 instance from the same inputs and
//   checks both against a queue-based reference built from the instruction
//   encoding rules.
module tb_imm_ext_stage;
  import imm_pkg::*;

  localparam int W = 73;  // {err, tag[7:0], imm[63:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [2:0]  imm_src;
  logic [24:0] in_data;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  imm_ext_stage #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .imm_src(imm_src), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_ext_stage #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .imm_src(imm_src), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
  );

  // ---------------- reference model ----------------
  // Rebuilds the instruction word and evaluates each immediate as a signed
  // integer sum of its fields; the 64-bit value is that integer widened.
  function automatic logic [63:0] ref_imm(input logic [2:0] src, input logic [24:0] d);
    logic [31:0] instr;
    int v;
    instr = {d, 7'b0};
    case (src)
      3'd0: v = $signed(instr) >>> 20;
      3'd1: v = ($signed(instr) >>> 25) * 32 + int'(instr[11:7]);
      3'd2: v = (instr[31] ? -4096 : 0) + int'(instr[7]) * 2048
                + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2;
      3'd3: v = (instr[31] ? -1048576 : 0) + int'(instr[19:12]) * 4096
                + int'(instr[20]) * 2048 + int'(instr[30:21]) * 2;
      3'd4: v = $signed(instr & 32'hFFFFF000);
      3'd5: v = int'(instr[19:15]);
      default: v = 0;
    endcase
    return longint'(v);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic         ev;
    logic [W-1:0] head;
    ev   = (exp_q.size() != 0);
    head = ev ? exp_q[0] : '0;
    chk("out_valid64", 64'(out_valid64), 64'(ev));
    chk("out_valid32", 64'(out_valid32), 64'(ev));
    chk("in_ready64", 64'(in_ready64), 64'(exp_q.size() != 2));
    chk("in_ready32", 64'(in_ready32), 64'(exp_q.size() != 2));
    chk("imm64", out_imm64, head[63:0]);
    chk("imm32", 64'(out_imm32), 64'(head[31:0]));
    chk("tag64", 64'(out_tag64), 64'(head[71:64]));
    chk("tag32", 64'(out_tag32), 64'(head[71:64]));
    chk("err64", 64'(out_err64), 64'(head[72]));
    chk("err32", 64'(out_err32), 64'(head[72]));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: check outputs at the falling edge, predict the
  // transfer, then update the model just after the rising edge.
  task automatic cycle();
    logic         do_push, do_pop;
    logic [W-1:0] ent;
    @(negedge clk);
    check_outputs();
    do_push = in_valid && (exp_q.size() != 2);
    do_pop  = (exp_q.size() != 0) && out_ready;
    ent     = {imm_src > 3'd5, in_tag, ref_imm(imm_src, in_data)};
    @(posedge clk);
    #1;
    if (flush) exp_q.delete();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ent);
    end
  endtask

  task automatic directed(input logic [2:0] src, input logic [31:0] instr,
                          input logic [7:0] tag, input logic [63:0] exp64,
                          input logic exp_err);
    in_valid  = 1'b1;
    imm_src   = src;
    in_data   = instr[31:7];
    in_tag    = tag;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("dir_valid", 64'(out_valid64), 64'd1);
    chk("dir_imm64", out_imm64, exp64);
    chk("dir_imm32", 64'(out_imm32), 64'(exp64[31:0]));
    chk("dir_err", 64'(out_err64), 64'(exp_err));
    chk("dir_tag", 64'(out_tag32), 64'(tag));
    cycle();
  endtask

  task automatic fill_two(input logic [7:0] t0, input logic [7:0] t1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm_src   = 3'd0;
    in_data   = 25'h1ABCDE;
    in_tag    = t0;
    cycle();
    in_tag = t1;
    cycle();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; imm_src = '0;
    in_data = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // I / B / U / J types
    directed(3'd0, 32'hFFF00093, 8'h11, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    directed(3'd2, 32'hFE000EE3, 8'h12, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    directed(3'd4, 32'h800000B7, 8'h13, 64'hFFFFFFFF80000000, 1'b0);
    directed(3'd3, 32'h0010006F, 8'h14, 64'h0000000000000800, 1'b0);
    // Z and illegal types
    directed(3'd5, 32'h000F8000, 8'h15, 64'h000000000000001F, 1'b0);
    directed(3'd6, 32'hFFFFFFFF, 8'h16, 64'h0, 1'b1);
    directed(3'd7, 32'h12345678, 8'h17, 64'h0, 1'b1);

    // Backpressure: A, B accepted, C stalls until a slot frees
    fill_two(8'hA0, 8'hB0);
    in_valid = 1'b1;
    in_tag   = 8'hC0;
    cycle();
    chk("bp_in_ready", 64'(in_ready64), 64'd0);
    out_ready = 1'b1;
    repeat (4) cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush with two buffered entries and a request in the same cycle
    fill_two(8'h21, 8'h22);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_tag   = 8'hEE;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", 64'(out_valid64), 64'd0);
    chk("flush_ready", 64'(in_ready32), 64'd1);
    repeat (2) cycle();

    // Reset while holding two entries
    fill_two(8'h31, 8'h32);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_valid", 64'(out_valid64), 64'd0);
    chk("rst_ready", 64'(in_ready64), 64'd1);
    chk("rst_imm", out_imm64, 64'd0);
    chk("rst_tag", 64'(out_tag32), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    directed(3'd1, 32'hFE000FA3, 8'h40, 64'hFFFFFFFFFFFFFFFF, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      imm_src   = 3'($urandom_range(0, 7));
      in_data   = 25'($urandom);
      in_tag    = 8'($urandom_range(0, 255));
      cycle();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
